// File: rtl/cond_unit.sv
// Execute-stage condition unit: architected NZCV register, ARM condition evaluation,
// side-effect gating and E/M boundary registers. Optional counters: COND_UNIT_STATS_EN.
module cond_unit #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ValidE,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic [3:0] CondE,
  input  logic [1:0] FlagWriteE,
  input  logic [3:0] ALUFlags,
  input  logic       PCSE,
  input  logic       BranchE,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       NoWriteE,
  output logic       CondExE,
  output logic       PCSrcE,
  output logic [3:0] Flags,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       PCSrcM
`ifdef COND_UNIT_STATS_EN
  ,
  output logic [31:0] ExecCount,
  output logic [31:0] SquashCount
`endif
);

  logic [3:0] flags_r;
  logic       live_s;
  logic       pass_s;
  logic       cond_ex_s;
  logic       pc_src_s;
  logic [3:0] flags_nxt_s;
  logic       reg_write_m_r;
  logic       mem_write_m_r;
  logic       pc_src_m_r;

  // Full ARM condition table against the {N,Z,C,V} register value.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Condition evaluation, gating and next-flag selection.
  always_comb begin
    live_s      = ValidE & ~FlushE & ~StallE;
    pass_s      = cond_pass(CondE, flags_r);
    cond_ex_s   = live_s & pass_s;
    pc_src_s    = cond_ex_s & (PCSE | BranchE);
    flags_nxt_s = flags_r;
    if (cond_ex_s && FlagWriteE[1]) begin
      flags_nxt_s[3:2] = ALUFlags[3:2];
    end else begin
      flags_nxt_s[3:2] = flags_r[3:2];
    end
    if (cond_ex_s && FlagWriteE[0]) begin
      flags_nxt_s[1:0] = ALUFlags[1:0];
    end else begin
      flags_nxt_s[1:0] = flags_r[1:0];
    end
  end

  // NZCV register and the E/M boundary; a squashed or stalled slot lands as a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_r       <= FLAG_RESET;
      reg_write_m_r <= 1'b0;
      mem_write_m_r <= 1'b0;
      pc_src_m_r    <= 1'b0;
    end else begin
      flags_r       <= flags_nxt_s;
      reg_write_m_r <= cond_ex_s & RegWriteE & ~NoWriteE;
      mem_write_m_r <= cond_ex_s & MemWriteE;
      pc_src_m_r    <= pc_src_s;
    end
  end

  assign CondExE   = cond_ex_s;
  assign PCSrcE    = pc_src_s;
  assign Flags     = flags_r;
  assign RegWriteM = reg_write_m_r;
  assign MemWriteM = mem_write_m_r;
  assign PCSrcM    = pc_src_m_r;

`ifdef COND_UNIT_STATS_EN
  logic [31:0] exec_count_r;
  logic [31:0] squash_count_r;

  // Executed and condition-failed instruction counters; both wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_count_r   <= 32'd0;
      squash_count_r <= 32'd0;
    end else begin
      if (cond_ex_s) begin
        exec_count_r <= exec_count_r + 32'd1;
      end else begin
        exec_count_r <= exec_count_r;
      end
      if (live_s && !pass_s) begin
        squash_count_r <= squash_count_r + 32'd1;
      end else begin
        squash_count_r <= squash_count_r;
      end
    end
  end

  assign ExecCount   = exec_count_r;
  assign SquashCount = squash_count_r;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed test-plan scenarios followed by
// randomized traffic compared against a behavioural NZCV model.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ValidE = 1'b0, StallE = 1'b0, FlushE = 1'b0;
  logic [3:0] CondE = 4'd0;
  logic [1:0] FlagWriteE = 2'd0;
  logic [3:0] ALUFlags = 4'd0;
  logic       PCSE = 1'b0, BranchE = 1'b0, RegWriteE = 1'b0, MemWriteE = 1'b0, NoWriteE = 1'b0;
  logic       CondExE, PCSrcE, RegWriteM, MemWriteM, PCSrcM;
  logic [3:0] Flags;
`ifdef COND_UNIT_STATS_EN
  logic [31:0] ExecCount, SquashCount;
  logic [31:0] m_exec = 32'd0, m_squash = 32'd0;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] m_flags = 4'd0;
  logic       m_rw = 1'b0, m_mw = 1'b0, m_pc = 1'b0;

  cond_unit #(.FLAG_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
    .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags), .PCSE(PCSE),
    .BranchE(BranchE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .NoWriteE(NoWriteE),
    .CondExE(CondExE), .PCSrcE(PCSrcE), .Flags(Flags), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .PCSrcM(PCSrcM)
`ifdef COND_UNIT_STATS_EN
    , .ExecCount(ExecCount), .SquashCount(SquashCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ARM pseudocode form: base test from cond[3:1], inverted by cond[0] except for 111x.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && c[3:1] != 3'd7) r = !r;
    return r;
  endfunction

  // Drives one Execute-stage cycle, checks same-cycle outputs, then the registered result.
  task automatic apply(input logic v, input logic st, input logic fl, input logic [3:0] c,
                       input logic [1:0] fw, input logic [3:0] alu, input logic pcs,
                       input logic br, input logic rw, input logic mw, input logic nw);
    logic live, p, ce, pc;
    logic [3:0] mask;
    ValidE = v; StallE = st; FlushE = fl; CondE = c; FlagWriteE = fw; ALUFlags = alu;
    PCSE = pcs; BranchE = br; RegWriteE = rw; MemWriteE = mw; NoWriteE = nw;
    #1;
    live = v && !fl && !st;
    p    = ref_pass(c, m_flags);
    ce   = live && p;
    pc   = ce && (pcs || br);
    check("CondExE", {31'd0, CondExE}, {31'd0, ce});
    check("PCSrcE", {31'd0, PCSrcE}, {31'd0, pc});
    mask = {fw[1], fw[1], fw[0], fw[0]};
    if (ce) m_flags = (m_flags & ~mask) | (alu & mask);
    m_rw = ce && rw && !nw;
    m_mw = ce && mw;
    m_pc = pc;
`ifdef COND_UNIT_STATS_EN
    if (ce) m_exec = m_exec + 32'd1;
    if (live && !p) m_squash = m_squash + 32'd1;
`endif
    @(posedge clk);
    #1;
    check("Flags", {28'd0, Flags}, {28'd0, m_flags});
    check("RegWriteM", {31'd0, RegWriteM}, {31'd0, m_rw});
    check("MemWriteM", {31'd0, MemWriteM}, {31'd0, m_mw});
    check("PCSrcM", {31'd0, PCSrcM}, {31'd0, m_pc});
`ifdef COND_UNIT_STATS_EN
    check("ExecCount", ExecCount, m_exec);
    check("SquashCount", SquashCount, m_squash);
`endif
  endtask

  initial begin
    #12 reset = 1'b1;
    @(posedge clk); #1;
    check("reset_flags", {28'd0, Flags}, 32'd0);
    check("reset_rwm", {31'd0, RegWriteM}, 32'd0);

    // Preset flags and M outputs, then pulse reset mid-cycle.
    apply(1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("preset_flags", {28'd0, Flags}, 32'hB);
    #2 reset = 1'b0;
    #1;
    check("async_flags", {28'd0, Flags}, 32'd0);
    check("async_rwm", {31'd0, RegWriteM}, 32'd0);
    check("async_mwm", {31'd0, MemWriteM}, 32'd0);
    check("async_pcm", {31'd0, PCSrcM}, 32'd0);
    m_flags = 4'd0; m_rw = 1'b0; m_mw = 1'b0; m_pc = 1'b0;
`ifdef COND_UNIT_STATS_EN
    m_exec = 32'd0; m_squash = 32'd0;
`endif
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // First post-reset instruction sees FLAG_RESET: EQ fails on Z=0.
    apply(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // SUBS then BEQ.
    apply(1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("subs_flags", {28'd0, Flags}, 32'h4);
    apply(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("beq_pcsrcm", {31'd0, PCSrcM}, 32'd1);

    // Partial flag write.
    apply(1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 4'b1110, 2'b10, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("partial_flags", {28'd0, Flags}, 32'h6);

    // Failed condition suppresses all side effects.
    apply(1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 4'b0000, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("fail_flags", {28'd0, Flags}, 32'h0);

    // Stall for two cycles, then release; then flush (with and without stall).
    apply(1'b1, 1'b1, 1'b0, 4'b1110, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 4'b1110, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stall_rwm", {31'd0, RegWriteM}, 32'd0);
    apply(1'b1, 1'b0, 1'b0, 4'b1110, 2'b00, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("unstall_rwm", {31'd0, RegWriteM}, 32'd1);
    apply(1'b1, 1'b0, 1'b1, 4'b1110, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 4'b1110, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("flush_flags", {28'd0, Flags}, 32'h0);

    // Signed conditions.
    apply(1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 4'b1011, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 4'b1010, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 4'b1100, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 4'b1010, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 4'b1101, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("nowrite_rwm", {31'd0, RegWriteM}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0), 4'($urandom), 2'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
